// File: rtl/aes_axis_out_tx.sv
// AES result transmitter: buffers 128-bit result blocks and streams them out
// as 32-bit AXI-Stream words, most-significant word first, once msg_done arrives.
module aes_axis_out_tx #(
    parameter int ADDR_WIDTH           = 9,
    parameter int DEPTH                = 512,
    parameter int BLK_WIDTH            = 128,
    parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                blk_w_e,
    input  logic [BLK_WIDTH-1:0]                blk_data,
    input  logic                                msg_done,
    output logic                                m00_axis_tvalid,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                m00_axis_tlast,
    input  logic                                m00_axis_tready,
    output logic                                busy,
    output logic                                tx_done,
    output logic                                overflow
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, FILL, RD, LATCH, SEND} state_t;

    state_t                 state, state_next;
    logic [CNT_W-1:0]       wr_cnt;
    logic [ADDR_WIDTH-1:0]  rd_ptr;
    logic [1:0]             word_cnt;
    logic [BLK_WIDTH-1:0]   mem [DEPTH];
    logic [BLK_WIDTH-1:0]   rd_data;
    logic [BLK_WIDTH-1:0]   shift_reg;
    logic                   accepting;
    logic                   wr_ok;
    logic                   wr_drop;
    logic                   handshake;
    logic                   last_blk;

    // wr_cnt is one bit wider than the address so a full buffer is distinguishable from empty
    always_comb begin
        accepting = (state == IDLE) || (state == FILL);
        wr_ok     = accepting && blk_w_e && (wr_cnt != CNT_W'(DEPTH));
        wr_drop   = accepting && blk_w_e && (wr_cnt == CNT_W'(DEPTH));
        handshake = (state == SEND) && m00_axis_tready;
        last_blk  = ({1'b0, rd_ptr} == (wr_cnt - CNT_W'(1)));
    end

    assign m00_axis_tvalid = (state == SEND);
    assign m00_axis_tdata  = shift_reg[BLK_WIDTH-1 -: C_M_AXIS_TDATA_WIDTH];
    assign m00_axis_tstrb  = '1;
    assign busy            = !accepting;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, FILL: begin
                // a write in the same cycle as msg_done still counts as part of the message
                if (msg_done && ((wr_cnt != '0) || wr_ok)) begin
                    state_next = RD;
                end else if (wr_ok) begin
                    state_next = FILL;
                end
            end
            RD:    state_next = LATCH;
            LATCH: state_next = SEND;
            SEND: begin
                if (handshake && (word_cnt == 2'd3)) begin
                    state_next = last_blk ? IDLE : RD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // block buffer has no reset; its contents are meaningless until rewritten
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_cnt[ADDR_WIDTH-1:0]] <= blk_data;
        end
        if (state == RD) begin
            rd_data <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt         <= '0;
            rd_ptr         <= '0;
            word_cnt       <= '0;
            shift_reg      <= '0;
            m00_axis_tlast <= 1'b0;
            tx_done        <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE, FILL: begin
                    if (wr_ok) begin
                        wr_cnt <= wr_cnt + CNT_W'(1);
                    end
                    if (wr_drop) begin
                        overflow <= 1'b1;
                    end
                    if (msg_done) begin
                        rd_ptr <= '0;
                        if ((wr_cnt == '0) && !wr_ok) begin
                            tx_done <= 1'b1;
                        end
                    end
                end
                LATCH: begin
                    shift_reg      <= rd_data;
                    word_cnt       <= '0;
                    m00_axis_tlast <= 1'b0;
                end
                SEND: begin
                    if (m00_axis_tready) begin
                        shift_reg      <= shift_reg << C_M_AXIS_TDATA_WIDTH;
                        word_cnt       <= word_cnt + 2'd1;
                        m00_axis_tlast <= (word_cnt == 2'd2) && last_blk;
                        if (word_cnt == 2'd3) begin
                            if (last_blk) begin
                                wr_cnt   <= '0;
                                rd_ptr   <= '0;
                                overflow <= 1'b0;
                                tx_done  <= 1'b1;
                            end else begin
                                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
